// File: rtl/commit_trace_buffer_if.sv
// Trace output stream of commit_trace_buffer: one 32-bit beat per valid/ready
// handshake, out_last flags the final beat of each record.
interface commit_trace_buffer_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/commit_trace_buffer.sv
// FIFO of retired-instruction records, serialized as 32-bit beats on the trace stream.
// Define TRACE_TIMESTAMP_EN to append a capture-cycle timestamp as a fifth beat.
module commit_trace_buffer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    commit_valid,
  input  logic [31:0]             commit_pc,
  input  logic [31:0]             commit_ins,
  input  logic                    commit_we,
  input  logic [4:0]              commit_rd,
  input  logic [31:0]             commit_wdata,
  commit_trace_buffer_if.master   trace,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty,
  output logic [15:0]             drop_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam logic [2:0] LAST_BEAT = 3'd4;
`else
  localparam logic [2:0] LAST_BEAT = 3'd3;
`endif

  logic [AW-1:0] head, tail;
  logic [2:0]    beat;
  logic [31:0]   cycle_cnt;
  logic          advance, pop, push, drop;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] ins_mem   [DEPTH];
  logic        we_mem    [DEPTH];
  logic [4:0]  rd_mem    [DEPTH];
  logic [31:0] wdata_mem [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_mem    [DEPTH];
`else
  logic        cycle_unused;
  assign cycle_unused = ^cycle_cnt;
`endif

  assign empty           = (level == '0);
  assign full            = (level == DEPTH_L);
  assign trace.out_valid = !empty;
  assign trace.out_last  = !empty && (beat == LAST_BEAT);

  assign advance = trace.out_valid && trace.out_ready;
  assign pop     = advance && trace.out_last;
  // A full FIFO still accepts a commit when the head record leaves this cycle.
  assign push    = commit_valid && (!full || pop);
  assign drop    = commit_valid && full && !pop;

  always_comb begin
    trace.out_data = '0;
    case (beat)
      3'd0:    trace.out_data = pc_mem[head];
      3'd1:    trace.out_data = ins_mem[head];
      3'd2:    trace.out_data = {we_mem[head], 26'b0, rd_mem[head]};
      3'd3:    trace.out_data = wdata_mem[head];
`ifdef TRACE_TIMESTAMP_EN
      3'd4:    trace.out_data = ts_mem[head];
`endif
      default: trace.out_data = '0;
    endcase
  end

  // Write data is masked at capture so beat 3 reads zero for non-writing instructions.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[tail]    <= commit_pc;
      ins_mem[tail]   <= commit_ins;
      we_mem[tail]    <= commit_we;
      rd_mem[tail]    <= commit_rd;
      wdata_mem[tail] <= commit_we ? commit_wdata : '0;
`ifdef TRACE_TIMESTAMP_EN
      ts_mem[tail]    <= cycle_cnt;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      level     <= '0;
      beat      <= '0;
      drop_cnt  <= '0;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (push) tail <= tail + AW'(1);
      if (pop) begin
        head <= head + AW'(1);
        beat <= '0;
      end else if (advance) begin
        beat <= beat + 3'd1;
      end
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: queue-based record model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_commit_trace_buffer;
  localparam int unsigned DEPTH = 8;
`ifdef TRACE_TIMESTAMP_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] commit_ins = '0;
  logic        commit_we = 1'b0;
  logic [4:0]  commit_rd = '0;
  logic [31:0] commit_wdata = '0;
  logic [$clog2(DEPTH):0] level;
  logic        full, empty;
  logic [15:0] drop_cnt;

  commit_trace_buffer_if trace();

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_ins(commit_ins),
    .commit_we(commit_we), .commit_rd(commit_rd), .commit_wdata(commit_wdata),
    .trace(trace), .level(level), .full(full), .empty(empty), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of whole records plus the beat index into the head one.
  typedef struct {
    logic [31:0] pc, ins;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata, ts;
  } rec_t;

  rec_t        q[$];
  rec_t        mr;
  int          beat_m = 0;
  int          drops_m = 0;
  logic [31:0] cyc_m = '0;
  bit          m_hs, m_last, m_free;

  function automatic logic [31:0] beat_word(input rec_t r, input int b);
    case (b)
      0:       return r.pc;
      1:       return r.ins;
      2:       return {r.we, 26'b0, r.rd};
      3:       return r.we ? r.wdata : 32'h0;
      default: return r.ts;
    endcase
  endfunction

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      q.delete();
      beat_m  = 0;
      drops_m = 0;
      cyc_m   = '0;
    end else begin
      m_hs   = (q.size() != 0) && trace.out_ready;
      m_last = m_hs && (beat_m == NB - 1);
      m_free = (q.size() < DEPTH) || m_last;
      if (m_hs) begin
        if (m_last) begin
          void'(q.pop_front());
          beat_m = 0;
        end else begin
          beat_m++;
        end
      end
      if (commit_valid) begin
        if (m_free) begin
          mr.pc = commit_pc; mr.ins = commit_ins; mr.we = commit_we;
          mr.rd = commit_rd; mr.wdata = commit_wdata; mr.ts = cyc_m;
          q.push_back(mr);
        end else if (drops_m < 65535) begin
          drops_m++;
        end
      end
      cyc_m = cyc_m + 32'd1;
    end
  end

  initial forever begin
    @(negedge clock);
    if (cmp_en) begin
      check("m_valid", trace.out_valid, q.size() != 0);
      check("m_level", level, q.size());
      check("m_full",  full,  q.size() == DEPTH);
      check("m_empty", empty, q.size() == 0);
      check("m_drop",  drop_cnt, drops_m);
      if (q.size() != 0) begin
        check("m_data", trace.out_data, beat_word(q[0], beat_m));
        check("m_last", trace.out_last, beat_m == NB - 1);
      end else begin
        check("m_last_idle", trace.out_last, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic commit1(input logic [31:0] pc, input logic [31:0] ins, input logic we,
                         input logic [4:0] rd, input logic [31:0] wd);
    commit_valid = 1'b1; commit_pc = pc; commit_ins = ins;
    commit_we = we; commit_rd = rd; commit_wdata = wd;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic expect_rec(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3,
                            input bit chk_ts, input logic [31:0] ts);
    logic [31:0] w [5];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = ts;
    trace.out_ready = 1'b1;
    for (int b = 0; b < NB; b++) begin
      if (b < 4 || chk_ts) check({tag, "_data"}, trace.out_data, w[b]);
      check({tag, "_last"}, trace.out_last, b == NB - 1);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] got [5];
  logic [31:0] prev;
  bit          prev_stall;
  int          n;

  initial begin
    trace.out_ready = 1'b0;
    tick();
    tick();
    cmp_en = 1'b1;
    check("rst_valid", trace.out_valid, 1'b0);
    check("rst_last",  trace.out_last,  1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full",  full,  1'b0);
    check("rst_level", level, 0);
    check("rst_drop",  drop_cnt, 0);
    reset = 1'b0;
    tick();

    // Single record, writing instruction.
    trace.out_ready = 1'b1;
    check("c1_valid_before", trace.out_valid, 1'b0);
    commit1(32'h00000040, 32'h2002000A, 1'b1, 5'd1, 32'h0000000A);
    check("c1_valid_next", trace.out_valid, 1'b1);
    expect_rec("c1", 32'h00000040, 32'h2002000A, 32'h80000001, 32'h0000000A, 1'b0, '0);
    check("c1_empty_after", empty, 1'b1);

    // Non-writing instruction: beat 3 forced to zero.
    commit1(32'h00000080, 32'h00502023, 1'b0, 5'd5, 32'hDEADBEEF);
    expect_rec("c2", 32'h00000080, 32'h00502023, 32'h00000005, 32'h00000000, 1'b0, '0);

    // Overflow: DEPTH+3 commits with consumer stalled.
    trace.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      commit_valid = 1'b1; commit_pc = 32'h1000 + 32'(4 * i); commit_ins = 32'(i);
      commit_we = 1'b1; commit_rd = 5'(i); commit_wdata = 32'(i);
      tick();
    end
    commit_valid = 1'b0;
    check("ovf_full",  full, 1'b1);
    check("ovf_level", level, DEPTH);
    check("ovf_drop",  drop_cnt, 3);

    // Commit into a full FIFO on the cycle its head record completes.
    trace.out_ready = 1'b1;
    for (int b = 0; b < NB - 1; b++) tick();
    check("fullpop_last", trace.out_last, 1'b1);
    commit1(32'hCAFE0000, 32'h1, 1'b1, 5'd2, 32'h3);
    check("fullpop_level", level, DEPTH);
    check("fullpop_drop",  drop_cnt, 3);
    for (int i = 1; i < DEPTH; i++) begin
      check("drain_pc", trace.out_data, 32'h1000 + 32'(4 * i));
      for (int b = 0; b < NB; b++) tick();
    end
    check("drain_new_pc", trace.out_data, 32'hCAFE0000);
    for (int b = 0; b < NB; b++) tick();
    check("drain_empty", empty, 1'b1);

    // Ready toggling every cycle: no duplicated/skipped beats, data held while stalled.
    commit1(32'h00002000, 32'h12345678, 1'b1, 5'd31, 32'h55AA55AA);
    n = 0; prev_stall = 1'b0; prev = '0;
    for (int c = 0; c < 20 && n < NB; c++) begin
      if (prev_stall) check("stall_stable", trace.out_data, prev);
      if (trace.out_valid && trace.out_ready) begin
        got[n] = trace.out_data;
        n++;
      end
      prev = trace.out_data;
      prev_stall = trace.out_valid && !trace.out_ready;
      tick();
      trace.out_ready = !trace.out_ready;
    end
    check("tog_count", n, NB);
    check("tog_b0", got[0], 32'h00002000);
    check("tog_b1", got[1], 32'h12345678);
    check("tog_b2", got[2], 32'h8000001F);
    check("tog_b3", got[3], 32'h55AA55AA);

    // Reset mid-record after beat 1.
    trace.out_ready = 1'b1;
    commit1(32'h00003000, 32'hAAAA0001, 1'b1, 5'd3, 32'h00000077);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("midrst_valid", trace.out_valid, 1'b0);
    check("midrst_level", level, 0);
    tick();
    check("midrst_valid_hold", trace.out_valid, 1'b0);
    reset = 1'b0;
    check("postrst_level", level, 0);
    tick(); tick(); tick();
    commit1(32'h00004000, 32'h00000004, 1'b1, 5'd4, 32'h00000044);
    expect_rec("postrst", 32'h00004000, 32'h00000004, 32'h80000004, 32'h00000044, 1'b1, 32'd3);

    // Randomized traffic: congested phase then mostly-ready phase, rare resets.
    for (int c = 0; c < 1500; c++) begin
      commit_valid = ($urandom_range(0, 99) < 60);
      commit_pc    = $urandom;
      commit_ins   = $urandom;
      commit_we    = 1'($urandom_range(0, 1));
      commit_rd    = 5'($urandom_range(0, 31));
      commit_wdata = $urandom;
      trace.out_ready = ($urandom_range(0, 99) < ((c < 500) ? 20 : 85));
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    commit_valid = 1'b0;
    reset = 1'b0;
    trace.out_ready = 1'b1;
    for (int c = 0; c < DEPTH * NB + 4; c++) tick();
    check("final_empty", empty, 1'b1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 16, record capacity; power of two, 2..256.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: commit_valid  input  1  one instruction retired by the CPU this cycle.
REQ-005 SHALL have port: commit_pc  input  32  PC of the retired instruction.
REQ-006 SHALL have port: commit_ins  input  32  instruction word of the retired instruction.
REQ-007 SHALL have port: commit_we  input  1  retired instruction wrote the register file.
REQ-008 SHALL have port: commit_rd  input  5  destination register index.
REQ-009 SHALL have port: commit_wdata  input  32  value written to commit_rd.
REQ-010 SHALL have port: out_valid  output  1  out_data holds a valid beat.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts the current beat.
REQ-012 SHALL have port: out_data  output  32  current beat of the head record.
REQ-013 SHALL have port: out_last  output  1  current beat is the final beat of its record.
REQ-014 SHALL have port: level  output  clog2(DEPTH)+1  number of stored records.
REQ-015 SHALL have port: full  output  1  level == DEPTH.
REQ-016 SHALL have port: empty  output  1  level == 0.
REQ-017 SHALL have port: drop_cnt  output  16  count of commits lost to overflow.

Function
REQ-018 SHALL capture {pc, ins, we, rd, wdata} into the FIFO tail on a rising edge with commit_valid=1 and a free slot; the record becomes visible (out_valid=1) in the following cycle.
REQ-019 SHALL define a free slot as level<DEPTH, or level==DEPTH with a final-beat handshake (out_valid & out_ready & out_last) in the same cycle.
REQ-020 SHALL, when commit_valid=1 and no slot is free, discard the commit and increment drop_cnt, saturating at 16'hFFFF.
REQ-021 SHALL serialize each record as beats 0: pc; 1: ins; 2: {we, 26'b0, rd}; 3: wdata, forced to 0 when we=0.
REQ-022 SHALL drive out_valid = !empty, with out_data/out_last taken combinationally from the head record and the beat counter.
REQ-023 SHALL advance the beat counter only on out_valid & out_ready; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on the final-beat handshake, pop the head record, return the beat counter to 0 and decrement level, unless a push occurs in the same cycle, in which case level is unchanged.
REQ-025 SHALL wrap head and tail pointers modulo DEPTH with no bubble cycle between back-to-back records.
REQ-026 SHALL keep a free-running 32-bit cycle counter that increments every clock and wraps from FFFFFFFF to 0.

Reset
REQ-027 SHALL, while reset=1, asynchronously clear pointers, level, beat counter, drop_cnt and cycle counter; outputs SHALL read out_valid=0, out_last=0, empty=1, full=0, level=0, drop_cnt=0.
REQ-028 SHALL discard any partially transmitted record when reset is asserted mid-record; after release, the first beat presented is beat 0 of a newly captured record.

Configuration
REQ-029 SHALL, with macro TRACE_TIMESTAMP_EN defined, store the cycle counter value at capture and emit it as an extra beat 4, making beat 4 the last beat.
REQ-030 SHALL, without TRACE_TIMESTAMP_EN, emit 4 beats per record, with beat 3 carrying out_last, and instantiate no timestamp storage.

Verification
REQ-031 SHALL cover: one commit (pc=00000040, ins=2002000A, we=1, rd=1, wdata=0000000A), out_ready=1 -> out_valid rises next cycle; beats 00000040, 2002000A, 80000001, 0000000A; out_last on beat 3; then empty=1.
REQ-032 SHALL cover: commit with we=0, rd=5, wdata=DEADBEEF -> beat 2 = 00000005, beat 3 = 00000000.
REQ-033 SHALL cover: out_ready=0, DEPTH+3 consecutive commits -> full=1, level=DEPTH, drop_cnt=3; after draining, records emerge in commit order.
REQ-034 SHALL cover: full FIFO with commit_valid=1 in the same cycle as a final-beat handshake -> commit accepted, level stays DEPTH, drop_cnt unchanged.
REQ-035 SHALL cover: out_ready toggled 1/0 every cycle during a record -> no beat duplicated or skipped, and out_data stable during stall cycles.
REQ-036 SHALL cover: reset pulsed after beat 1 of a record -> out_valid=0 during reset; level=0 after release; next commit starts at beat 0; with TRACE_TIMESTAMP_EN, beat 4 equals the capture cycle count counted from reset release.
